vga_frame_scaler: RTL and testbench
===================================

# vga_frame_scaler

Parametrised successor of the fixed 80x60 framebuffer display stage. It reads a framebuffer of configurable size and pixel format, upscales each stored pixel by an integer power-of-two factor, and applies a frame-synchronous colour mode. It drives fully registered VGA colour and sync outputs whose latency is aligned to a configurable memory read latency. It sits between the VGA sync generator and the framebuffer RAM read port.

## Interface
Parameters:
- c_synch_act, 0, active level of hsync/vsync
- c_img_cols, 80, stored image width in pixels
- c_img_rows, 60, stored image height in pixels
- c_nb_img_pxls, 13, framebuffer address width; must be at least ceil(log2(cols*rows))
- c_scale_log2, 2, upscale exponent S, range 0..3; window is (cols<<S) x (rows<<S)
- c_mem_lat, 1, framebuffer read latency in clk cycles, range 1..4
- c_nb_buf_red, c_nb_buf_green, c_nb_buf_blue, 4/4/4, stored channel widths
- c_nb_buf, sum of the three channel widths, memory word width
- c_nb_out, 4, output channel width, range 4..8

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-low
- new_pxl  in  1  one-clk pixel-rate strobe from the sync generator
- visible  in  1  active video area
- hsync, vsync  in  1 each  raw syncs
- col, row  in  10 each  current pixel coordinates
- mode  in  2  colour mode request
- bg_color  in  3*c_nb_out  colour for visible pixels outside the window, ordered {r,g,b}
- frame_pixel  in  c_nb_buf  RAM data, layout {r,g,b} MSB-first
- frame_addr  out  c_nb_img_pxls  RAM read address, registered
- frame_done  out  1  one-clk pulse after the last window pixel
- hsync_out, vsync_out  out  1 each  delayed syncs
- vga_red, vga_green, vga_blue  out  c_nb_out each  registered colour

## Operation
Window definitions:
- Let W = c_img_cols<<S and H = c_img_rows<<S.
- in_win = (col < W) && (row < H).

Address generator (state: x_sub, y_sub, both S bits; line_base; frame_addr):
- On new_pxl with in_win and col != W-1:
  - x_sub increments.
  - When x_sub wraps from 2^S-1 to 0, frame_addr increments.
- On new_pxl with in_win and col == W-1:
  - x_sub is set to 0.
  - If y_sub == 2^S-1: line_base and frame_addr are both set to line_base+c_img_cols, and y_sub is set to 0.
  - Otherwise: frame_addr is set to line_base and y_sub increments. The same stored line is re-read.
- row >= H: x_sub, y_sub, line_base and frame_addr all clear to 0, regardless of new_pxl.
- With S=0 the generator degenerates to one address per window pixel.
- frame_done pulses on the clk following new_pxl at col==W-1, row==H-1.

Mode shadow register:
- mode_q loads from mode only on clk edges where vsync == c_synch_act.
- A mode change mid-frame never takes effect before the next vsync.
- Mode decoding:
  - 0: RGB, each channel taken directly from its field.
  - 1: grey; the green field drives all three outputs.
  - 2: inverted RGB, bitwise NOT of each field.
  - 3: test bars; frame_pixel is ignored and the window is split into 8 equal vertical bars by col*8/W. Bar index b drives red={c_nb_out{b[2]}}, green={c_nb_out{b[1]}}, blue={c_nb_out{b[0]}}.

Width conversion (buffer field to c_nb_out):
- A field narrower than c_nb_out is MSB-aligned and filled by repeating the field bits from the MSB downward.
- A field wider than c_nb_out is truncated to its MSBs.

Output select:
- !visible: all colour outputs are 0.
- visible && !in_win: bg_color.
- visible && in_win: the mode-decoded pixel.

## Timing
- Control pipeline: visible, in_win, hsync, vsync and the bar index pass through c_mem_lat+1 register stages. This aligns them with frame_pixel, which is valid c_mem_lat clks after frame_addr.
- Latency from input sync/coordinates to hsync_out, vsync_out and colour outputs is exactly c_mem_lat+1 clks, constant in every mode.
- Reset (rst=0) values:
  - frame_addr, line_base, x_sub, y_sub = 0
  - mode_q = 0
  - frame_done = 0
  - colour outputs = 0
  - hsync_out, vsync_out and all pipeline sync stages = ~c_synch_act
  - all other pipeline stages = 0
- Reset release mid-frame: the generator runs from address 0. Addresses are correct from the first row >= H after release.
- Simultaneous vsync-active and row >= H clear is legal; both take effect on the same edge.

## Test plan
- S=2, 80x60, mode 0, ramp RAM (word = address): window line 0 shows each address on 4 consecutive pixels. Lines 0-3 re-read addresses 0..79; line 4 starts at 80; last address is 4799.
- S=0, c_mem_lat=3: hsync pulse at input emerges on hsync_out exactly 4 clks later; pixel (0,0) colour is aligned with the first visible output pixel.
- Mode 1 with frame_pixel=12'hA5C: red=green=blue=4'h5. Mode 2 with the same word: {r,g,b}={5,A,3}.
- Mode written 0 to 3 mid-frame: output stays RGB until the vsync; the next frame shows 8 bars, bar 5 = {F,0,F}.
- c_nb_out=8, 4-bit field 4'hB: output 8'hBB. visible pixel at col=W with bg_color=24'h102030: output {10,20,30}.
- Assert rst low at row 100 while S=2: all outputs go to reset values immediately. After release, frame_done pulses once per subsequent frame and frame_addr==0 at each frame start.

Source files
------------

// File: rtl/vga_frame_scaler.sv
// Framebuffer display stage: integer power-of-two upscaling, frame-synchronous colour modes
// and a control pipeline aligned to the framebuffer read latency.
module vga_frame_scaler #(
   parameter logic c_synch_act    = 1'b0,
   parameter int   c_img_cols     = 80,
   parameter int   c_img_rows     = 60,
   parameter int   c_nb_img_pxls  = 13,
   parameter int   c_scale_log2   = 2,
   parameter int   c_mem_lat      = 1,
   parameter int   c_nb_buf_red   = 4,
   parameter int   c_nb_buf_green = 4,
   parameter int   c_nb_buf_blue  = 4,
   parameter int   c_nb_buf       = c_nb_buf_red + c_nb_buf_green + c_nb_buf_blue,
   parameter int   c_nb_out       = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      new_pxl,
   input  logic                      visible,
   input  logic                      hsync,
   input  logic                      vsync,
   input  logic [9:0]                col,
   input  logic [9:0]                row,
   input  logic [1:0]                mode,
   input  logic [3*c_nb_out-1:0]     bg_color,
   input  logic [c_nb_buf-1:0]       frame_pixel,
   output logic [c_nb_img_pxls-1:0]  frame_addr,
   output logic                      frame_done,
   output logic                      hsync_out,
   output logic                      vsync_out,
   output logic [c_nb_out-1:0]       vga_red,
   output logic [c_nb_out-1:0]       vga_green,
   output logic [c_nb_out-1:0]       vga_blue
);

   localparam int W_PX  = c_img_cols << c_scale_log2;
   localparam int H_PX  = c_img_rows << c_scale_log2;
   localparam int SUB_W = (c_scale_log2 > 0) ? c_scale_log2 : 1;
   localparam int R_LSB = c_nb_buf_green + c_nb_buf_blue;
   localparam int G_LSB = c_nb_buf_blue;

   localparam logic [10:0]              WIN_W     = 11'(W_PX);
   localparam logic [10:0]              WIN_H     = 11'(H_PX);
   localparam logic [10:0]              LAST_COL  = 11'(W_PX - 1);
   localparam logic [10:0]              LAST_ROW  = 11'(H_PX - 1);
   localparam logic [12:0]              BAR_DIV   = 13'(W_PX);
   localparam logic [SUB_W-1:0]         SUB_MAX   = SUB_W'((1 << c_scale_log2) - 1);
   localparam logic [SUB_W-1:0]         SUB_ONE   = SUB_W'(1);
   localparam logic [c_nb_img_pxls-1:0] ADDR_ONE  = c_nb_img_pxls'(1);
   localparam logic [c_nb_img_pxls-1:0] LINE_STEP = c_nb_img_pxls'(c_img_cols);

   // Narrow fields repeat from their MSB downward; wide fields keep their MSBs.
   function automatic logic [c_nb_out-1:0] widen(input logic [c_nb_buf-1:0] word,
                                                 input int lsb, input int nb);
      logic [c_nb_out-1:0] res;
      res = '0;
      for (int i = 0; i < c_nb_out; i++) begin
         res[i] = word[lsb + nb - 1 - ((c_nb_out - 1 - i) % nb)];
      end
      return res;
   endfunction

   logic                     in_win_s, row_in_s, last_col_s, last_row_s;
   logic [2:0]               bar_s;
   logic [12:0]              col8_s;
   logic [SUB_W-1:0]         x_sub_r, y_sub_r;
   logic [c_nb_img_pxls-1:0] line_base_r;
   logic [1:0]               mode_q_r;
   logic                     vis_p_r [c_mem_lat];
   logic                     win_p_r [c_mem_lat];
   logic                     hs_p_r  [c_mem_lat];
   logic                     vs_p_r  [c_mem_lat];
   logic [2:0]               bar_p_r [c_mem_lat];
   logic [c_nb_out-1:0]      red_s, green_s, blue_s;
   logic [c_nb_out-1:0]      pix_r_s, pix_g_s, pix_b_s;

   assign row_in_s   = {1'b0, row} < WIN_H;
   assign in_win_s   = ({1'b0, col} < WIN_W) && row_in_s;
   assign last_col_s = {1'b0, col} == LAST_COL;
   assign last_row_s = {1'b0, row} == LAST_ROW;
   assign col8_s     = {col, 3'b000};
   assign bar_s      = 3'(col8_s / BAR_DIV);

   // Address generator: each stored pixel repeats 2^S times per line, each line 2^S times.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         x_sub_r     <= '0;
         y_sub_r     <= '0;
         line_base_r <= '0;
         frame_addr  <= '0;
      end else if (!row_in_s) begin
         x_sub_r     <= '0;
         y_sub_r     <= '0;
         line_base_r <= '0;
         frame_addr  <= '0;
      end else if (new_pxl && in_win_s) begin
         if (last_col_s) begin
            x_sub_r <= '0;
            if (y_sub_r == SUB_MAX) begin
               line_base_r <= line_base_r + LINE_STEP;
               frame_addr  <= line_base_r + LINE_STEP;
               y_sub_r     <= '0;
            end else begin
               frame_addr <= line_base_r;
               y_sub_r    <= y_sub_r + SUB_ONE;
            end
         end else if (x_sub_r == SUB_MAX) begin
            x_sub_r    <= '0;
            frame_addr <= frame_addr + ADDR_ONE;
         end else begin
            x_sub_r <= x_sub_r + SUB_ONE;
         end
      end
   end

   // End-of-window pulse and the mode shadow that only updates during vsync.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         frame_done <= 1'b0;
         mode_q_r   <= 2'b00;
      end else begin
         frame_done <= new_pxl && in_win_s && last_col_s && last_row_s;
         if (vsync == c_synch_act) begin
            mode_q_r <= mode;
         end
      end
   end

   // Control pipeline delays coordinates-derived flags until frame_pixel is valid.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int k = 0; k < c_mem_lat; k++) begin
            vis_p_r[k] <= 1'b0;
            win_p_r[k] <= 1'b0;
            hs_p_r[k]  <= ~c_synch_act;
            vs_p_r[k]  <= ~c_synch_act;
            bar_p_r[k] <= 3'b000;
         end
      end else begin
         vis_p_r[0] <= visible;
         win_p_r[0] <= in_win_s;
         hs_p_r[0]  <= hsync;
         vs_p_r[0]  <= vsync;
         bar_p_r[0] <= bar_s;
         for (int k = 1; k < c_mem_lat; k++) begin
            vis_p_r[k] <= vis_p_r[k-1];
            win_p_r[k] <= win_p_r[k-1];
            hs_p_r[k]  <= hs_p_r[k-1];
            vs_p_r[k]  <= vs_p_r[k-1];
            bar_p_r[k] <= bar_p_r[k-1];
         end
      end
   end

   // Mode decode of the aligned memory word.
   always_comb begin
      pix_r_s = '0;
      pix_g_s = '0;
      pix_b_s = '0;
      case (mode_q_r)
         2'd0: begin
            pix_r_s = widen(frame_pixel, R_LSB, c_nb_buf_red);
            pix_g_s = widen(frame_pixel, G_LSB, c_nb_buf_green);
            pix_b_s = widen(frame_pixel, 0, c_nb_buf_blue);
         end
         2'd1: begin
            pix_r_s = widen(frame_pixel, G_LSB, c_nb_buf_green);
            pix_g_s = pix_r_s;
            pix_b_s = pix_r_s;
         end
         2'd2: begin
            pix_r_s = widen(~frame_pixel, R_LSB, c_nb_buf_red);
            pix_g_s = widen(~frame_pixel, G_LSB, c_nb_buf_green);
            pix_b_s = widen(~frame_pixel, 0, c_nb_buf_blue);
         end
         2'd3: begin
            pix_r_s = {c_nb_out{bar_p_r[c_mem_lat-1][2]}};
            pix_g_s = {c_nb_out{bar_p_r[c_mem_lat-1][1]}};
            pix_b_s = {c_nb_out{bar_p_r[c_mem_lat-1][0]}};
         end
         default: begin
            pix_r_s = '0;
            pix_g_s = '0;
            pix_b_s = '0;
         end
      endcase
   end

   // Output select between blanking, background and window pixel.
   always_comb begin
      red_s   = '0;
      green_s = '0;
      blue_s  = '0;
      if (!vis_p_r[c_mem_lat-1]) begin
         red_s   = '0;
         green_s = '0;
         blue_s  = '0;
      end else if (!win_p_r[c_mem_lat-1]) begin
         red_s   = bg_color[3*c_nb_out-1 -: c_nb_out];
         green_s = bg_color[2*c_nb_out-1 -: c_nb_out];
         blue_s  = bg_color[c_nb_out-1:0];
      end else begin
         red_s   = pix_r_s;
         green_s = pix_g_s;
         blue_s  = pix_b_s;
      end
   end

   // Final register stage for colour and syncs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hsync_out <= ~c_synch_act;
         vsync_out <= ~c_synch_act;
         vga_red   <= '0;
         vga_green <= '0;
         vga_blue  <= '0;
      end else begin
         hsync_out <= hs_p_r[c_mem_lat-1];
         vsync_out <= vs_p_r[c_mem_lat-1];
         vga_red   <= red_s;
         vga_green <= green_s;
         vga_blue  <= blue_s;
      end
   end

endmodule

// File: tb/tb_vga_frame_scaler.sv
// Randomized bench for vga_frame_scaler: a compact raster generator, a latency-modelled RAM
// and a coordinate-level reference model of addresses, colours, syncs and frame_done.
module tb_vga_frame_scaler;

   localparam int   COLS = 16, ROWS = 8, S = 2, LAT = 2;
   localparam int   NR = 4, NG = 8, NB = 3, NBUF = NR + NG + NB, NO = 6, AW = 8;
   localparam logic ACT = 1'b0;
   localparam int   W = COLS << S, H = ROWS << S;
   localparam int   TOT_C = 80, TOT_R = 40, VIS_C = 72, VIS_R = 36;

   logic            clk = 1'b0;
   logic            rst = 1'b0;
   logic            new_pxl = 1'b0, visible = 1'b0;
   logic            hsync = ~ACT, vsync = ~ACT;
   logic [9:0]      col = '0, row = '0;
   logic [1:0]      mode = 2'd0;
   logic [3*NO-1:0] bg_color = '0;
   logic [NBUF-1:0] frame_pixel;
   logic [AW-1:0]   frame_addr;
   logic            frame_done, hsync_out, vsync_out;
   logic [NO-1:0]   vga_red, vga_green, vga_blue;

   vga_frame_scaler #(
      .c_synch_act(ACT), .c_img_cols(COLS), .c_img_rows(ROWS), .c_nb_img_pxls(AW),
      .c_scale_log2(S), .c_mem_lat(LAT), .c_nb_buf_red(NR), .c_nb_buf_green(NG),
      .c_nb_buf_blue(NB), .c_nb_buf(NBUF), .c_nb_out(NO)
   ) dut (
      .clk(clk), .rst(rst), .new_pxl(new_pxl), .visible(visible), .hsync(hsync),
      .vsync(vsync), .col(col), .row(row), .mode(mode), .bg_color(bg_color),
      .frame_pixel(frame_pixel), .frame_addr(frame_addr), .frame_done(frame_done),
      .hsync_out(hsync_out), .vsync_out(vsync_out), .vga_red(vga_red),
      .vga_green(vga_green), .vga_blue(vga_blue)
   );

   always #5 clk = ~clk;

   // Framebuffer RAM with LAT cycles of read latency.
   logic [NBUF-1:0] mem [256];
   logic [NBUF-1:0] rd  [LAT];
   always @(posedge clk) begin
      rd[0] <= mem[frame_addr];
      for (int k = 1; k < LAT; k++) rd[k] <= rd[k-1];
   end
   assign frame_pixel = rd[LAT-1];

   typedef struct {
      bit            chk;
      int            c, r;
      logic [NO-1:0] er, eg, eb;
      logic          hs, vs;
   } exp_t;

   exp_t q[$];
   int   n_chk = 0, n_fail = 0;
   int   mode_req = 0, mode_eff = 0;
   bit   chk_en = 1'b0, fd_exp = 1'b0;

   // Field to output width: repeat the field end to end and keep the top NO bits.
   function automatic logic [NO-1:0] conv(input int f, input int nb);
      logic [63:0] rep;
      rep = 64'd0;
      for (int k = 0; k < 8; k++) rep = (rep << nb) | 64'(f);
      return NO'(rep >> (8 * nb - NO));
   endfunction

   task automatic pixel(input int c, input int r, input bit strobe);
      exp_t e;
      bit   win, vis;
      int   ea, wd, fr, fg, fb, b;
      @(negedge clk);
      if (q.size() == LAT + 1) begin
         e = q.pop_front();
         n_chk++;
         if ({hsync_out, vsync_out} !== {e.hs, e.vs}) begin
            n_fail++;
            $display("FAIL sync at (%0d,%0d): got %b%b want %b%b", e.c, e.r,
                     hsync_out, vsync_out, e.hs, e.vs);
         end
         if (e.chk) begin
            n_chk++;
            if ({vga_red, vga_green, vga_blue} !== {e.er, e.eg, e.eb}) begin
               n_fail++;
               $display("FAIL colour at (%0d,%0d) mode %0d: got %h/%h/%h want %h/%h/%h", e.c, e.r,
                        mode_eff, vga_red, vga_green, vga_blue, e.er, e.eg, e.eb);
            end
         end
      end
      n_chk++;
      if (frame_done !== fd_exp) begin
         n_fail++;
         $display("FAIL frame_done before (%0d,%0d): got %b want %b", c, r, frame_done, fd_exp);
      end
      col     = 10'(c);
      row     = 10'(r);
      new_pxl = strobe;
      vis     = (c < VIS_C) && (r < VIS_R);
      visible = vis;
      hsync   = (c >= 74 && c < 77) ? ACT : ~ACT;
      vsync   = (r >= 37 && r < 39) ? ACT : ~ACT;
      mode    = 2'(mode_req);
      if (r >= H) chk_en = 1'b1;
      win = (c < W) && (r < H);
      ea  = (r >> S) * COLS + (c >> S);
      if (win && chk_en) begin
         n_chk++;
         if (frame_addr !== AW'(ea)) begin
            n_fail++;
            $display("FAIL frame_addr at (%0d,%0d): got %0d want %0d", c, r, frame_addr, ea);
         end
      end
      e.chk = chk_en; e.c = c; e.r = r; e.hs = hsync; e.vs = vsync;
      e.er = '0; e.eg = '0; e.eb = '0;
      if (vis && !win) begin
         {e.er, e.eg, e.eb} = bg_color;
      end else if (vis) begin
         wd = int'(mem[ea]);
         fr = (wd >> (NG + NB)) & ((1 << NR) - 1);
         fg = (wd >> NB) & ((1 << NG) - 1);
         fb = wd & ((1 << NB) - 1);
         b  = (c * 8) / W;
         case (mode_eff)
            0: begin e.er = conv(fr, NR); e.eg = conv(fg, NG); e.eb = conv(fb, NB); end
            1: begin e.er = conv(fg, NG); e.eg = e.er; e.eb = e.er; end
            2: begin
               e.er = conv(fr ^ ((1 << NR) - 1), NR);
               e.eg = conv(fg ^ ((1 << NG) - 1), NG);
               e.eb = conv(fb ^ ((1 << NB) - 1), NB);
            end
            default: begin
               e.er = ((b >> 2) & 1) ? '1 : '0;
               e.eg = ((b >> 1) & 1) ? '1 : '0;
               e.eb = (b & 1) ? '1 : '0;
            end
         endcase
      end
      q.push_back(e);
      if (vsync == ACT) mode_eff = mode_req;
      fd_exp = strobe && (c == W - 1) && (r == H - 1);
   endtask

   task automatic run_frame(input int m0, input int m1, input int r0, input int r1);
      bg_color = 18'($urandom);
      for (int r = r0; r <= r1; r++) begin
         if (r == r0) mode_req = m0;
         if (r == 10) mode_req = m1;
         for (int c = 0; c < TOT_C; c++) begin
            if ($urandom_range(0, 7) == 0) pixel(c, r, 1'b0);
            pixel(c, r, 1'b1);
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      repeat (3) @(negedge clk);
      n_chk++;
      if ({frame_addr, frame_done, hsync_out, vsync_out, vga_red, vga_green, vga_blue} !==
          {{AW{1'b0}}, 1'b0, ~ACT, ~ACT, {3*NO{1'b0}}}) begin
         n_fail++;
         $display("FAIL reset: got addr %0d done %b syncs %b%b rgb %h/%h/%h", frame_addr,
                  frame_done, hsync_out, vsync_out, vga_red, vga_green, vga_blue);
      end
      rst = 1'b1;
   endtask

   task automatic test_rgb();
      run_frame(0, 0, 0, TOT_R - 1);
      run_frame(0, 0, 0, TOT_R - 1);
   endtask

   task automatic test_modes();
      run_frame(0, 3, 0, TOT_R - 1);
      run_frame(3, 1, 0, TOT_R - 1);
      run_frame(1, 2, 0, TOT_R - 1);
      run_frame(2, int'($urandom_range(0, 3)), 0, TOT_R - 1);
   endtask

   task automatic test_reset_midframe();
      run_frame(0, 2, 0, 19);
      @(negedge clk);
      rst = 1'b0;
      #1;
      n_chk++;
      if ({frame_addr, frame_done, hsync_out, vsync_out, vga_red, vga_green, vga_blue} !==
          {{AW{1'b0}}, 1'b0, ~ACT, ~ACT, {3*NO{1'b0}}}) begin
         n_fail++;
         $display("FAIL midframe reset: got addr %0d done %b syncs %b%b rgb %h/%h/%h", frame_addr,
                  frame_done, hsync_out, vsync_out, vga_red, vga_green, vga_blue);
      end
      q.delete();
      chk_en   = 1'b0;
      fd_exp   = 1'b0;
      mode_eff = 0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      run_frame(2, 2, 20, TOT_R - 1);
      run_frame(1, 3, 0, TOT_R - 1);
      run_frame(3, 0, 0, TOT_R - 1);
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = NBUF'($urandom);
      test_reset();
      test_rgb();
      test_modes();
      test_reset_midframe();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
